// File: rtl/regressor_stream.sv
// Streaming least-squares line fitter: buffers up to DEPTH (x,y) samples, solves slope and
// intercept with one shared serial divider, then replays the buffer to accumulate the residual.
module regressor_stream #(
  parameter int unsigned W     = 20,
  parameter int unsigned FRAC  = 10,
  parameter int unsigned DEPTH = 150,
  localparam int unsigned NW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] num,
  input  logic          err_mode,
  input  logic [W-1:0]  xi,
  input  logic [W-1:0]  yi,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          busy,
  output logic          ready,
  output logic [W-1:0]  b0,
  output logic [W-1:0]  b1,
  output logic [W-1:0]  error,
  output logic          div_zero
);

  localparam int unsigned AW = W + NW;             // Sx, Sy, residual accumulator
  localparam int unsigned QW = 2 * W + NW;         // Sxx, Sxy
  localparam int unsigned MW = 2 * W + 2 * NW + 2; // Nm, Dm (exact)
  localparam int unsigned DW = MW + FRAC;          // divider operand width
  localparam int unsigned CW = $clog2(DW + 1);
  localparam int unsigned BW = AW + W + 1;         // intercept numerator
  localparam int unsigned RW = 2 * W + 2;          // residual
  localparam int unsigned TW = 2 * RW;             // residual term

  localparam logic signed [DW:0] SMAX = {{(DW - W + 2){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [DW:0] SMIN = {{(DW - W + 2){1'b1}}, {(W - 1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle, StLoad, StNum, StDivB1, StB0, StDivB0, StResid, StDone
  } state_e;

  state_e state_q, state_d;

  logic [NW-1:0]        n_q, k_q, n_clamp;
  logic                 mode_q;
  logic signed [AW-1:0] sx_q, sy_q;
  logic signed [QW-1:0] sxx_q, sxy_q;
  logic [DW-1:0]        dvd_q, rem_q, dvs_q;
  logic [CW-1:0]        cnt_q;
  logic                 neg_q;
  logic signed [W-1:0]  b1w_q, b0w_q;
  logic                 dz_q;
  logic [AW-1:0]        acc_q;
  logic signed [W-1:0]  b0_q, b1_q;
  logic [W-1:0]         err_q;
  logic                 div_zero_q;

  logic signed [W-1:0]  mem_x [DEPTH];
  logic signed [W-1:0]  mem_y [DEPTH];

  logic accept, take, last_k, div_last, dm_zero;

  function automatic logic signed [W-1:0] sat_w(input logic signed [DW:0] v);
    if (v > SMAX) return {1'b0, {(W - 1){1'b1}}};
    if (v < SMIN) return {1'b1, {(W - 1){1'b0}}};
    return v[W-1:0];
  endfunction

  assign in_ready = (state_q == StLoad);
  assign busy     = (state_q != StIdle) && (state_q != StDone);
  assign ready    = (state_q == StDone);
  assign b0       = b0_q;
  assign b1       = b1_q;
  assign error    = err_q;
  assign div_zero = div_zero_q;

  assign accept   = start && ((state_q == StIdle) || (state_q == StDone));
  assign take     = in_valid && in_ready;
  assign last_k   = (k_q == n_q - NW'(1));
  assign div_last = (cnt_q == CW'(DW - 1));

  always_comb begin
    n_clamp = num;
    if (num < NW'(2)) begin
      n_clamp = NW'(2);
    end else if (num > NW'(DEPTH)) begin
      n_clamp = NW'(DEPTH);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  if (take && last_k) state_d = StNum;
      StNum:   state_d = dm_zero ? StB0 : StDivB1;
      StDivB1: if (div_last) state_d = StB0;
      StB0:    state_d = StDivB0;
      StDivB0: if (div_last) state_d = StResid;
      StResid: if (last_k) state_d = StDone;
      StDone:  if (start) state_d = StLoad;
      default: state_d = StIdle;
    endcase
  end

  // Load-phase accumulation terms
  logic signed [2*W-1:0] xi_e, yi_e, xx, xy;
  logic signed [AW-1:0]  x_a, y_a;
  logic signed [QW-1:0]  xx_a, xy_a;

  always_comb begin
    xi_e = {{W{xi[W-1]}}, xi};
    yi_e = {{W{yi[W-1]}}, yi};
    xx   = xi_e * xi_e;
    xy   = xi_e * yi_e;
    x_a  = {{NW{xi[W-1]}}, xi};
    y_a  = {{NW{yi[W-1]}}, yi};
    xx_a = {{NW{xx[2*W-1]}}, xx};
    xy_a = {{NW{xy[2*W-1]}}, xy};
  end

  // Slope numerator/denominator
  logic signed [MW-1:0] n_m, sx_m, sy_m, sxx_m, sxy_m, nm, dm;
  logic [MW-1:0]        nm_mag, dm_mag;

  always_comb begin
    n_m    = {{(MW - NW){1'b0}}, n_q};
    sx_m   = {{(MW - AW){sx_q[AW-1]}}, sx_q};
    sy_m   = {{(MW - AW){sy_q[AW-1]}}, sy_q};
    sxx_m  = {{(MW - QW){sxx_q[QW-1]}}, sxx_q};
    sxy_m  = {{(MW - QW){sxy_q[QW-1]}}, sxy_q};
    nm     = n_m * sxy_m - sx_m * sy_m;
    dm     = n_m * sxx_m - sx_m * sx_m;
    nm_mag = nm[MW-1] ? -nm : nm;
    dm_mag = dm[MW-1] ? -dm : dm;
    dm_zero = (dm == '0);
  end

  // Intercept numerator: Sy - (b1*Sx)>>>FRAC
  logic signed [AW+W-1:0] b1_x, sx_x, b1sx, b1sx_sh;
  logic signed [BW-1:0]   num0;
  logic [BW-1:0]          num0_mag;

  always_comb begin
    b1_x     = {{AW{b1w_q[W-1]}}, b1w_q};
    sx_x     = {{W{sx_q[AW-1]}}, sx_q};
    b1sx     = b1_x * sx_x;
    b1sx_sh  = b1sx >>> FRAC;
    num0     = {{(BW - AW){sy_q[AW-1]}}, sy_q} - {b1sx_sh[AW+W-1], b1sx_sh};
    num0_mag = num0[BW-1] ? -num0 : num0;
  end

  // Restoring divider step; the trial difference's sign bit is the inverted quotient bit
  logic [DW:0]          rem_sh, diff;
  logic                 qbit;
  logic [DW-1:0]        quo_nx, rem_nx;
  logic signed [DW:0]   q_signed;
  logic signed [W-1:0]  q_sat;

  always_comb begin
    rem_sh   = {rem_q, dvd_q[DW-1]};
    diff     = rem_sh - {1'b0, dvs_q};
    qbit     = ~diff[DW];
    rem_nx   = qbit ? diff[DW-1:0] : rem_sh[DW-1:0];
    quo_nx   = {dvd_q[DW-2:0], qbit};
    q_signed = neg_q ? -$signed({1'b0, quo_nx}) : $signed({1'b0, quo_nx});
    q_sat    = sat_w(q_signed);
  end

  // Residual replay
  logic signed [W-1:0]   x_rd, y_rd;
  logic signed [2*W-1:0] px, px_sh;
  logic signed [RW-1:0]  r;
  logic [RW-1:0]         r_mag;
  logic [TW-1:0]         r_ext, sq, term, sum;
  logic [AW-1:0]         acc_nx;
  logic [W-1:0]          err_nx;

  always_comb begin
    x_rd   = mem_x[k_q];
    y_rd   = mem_y[k_q];
    px     = {{W{b1w_q[W-1]}}, b1w_q} * {{W{x_rd[W-1]}}, x_rd};
    px_sh  = px >>> FRAC;
    r      = {{(RW - W){y_rd[W-1]}}, y_rd} - {{(RW - W){b0w_q[W-1]}}, b0w_q}
             - {{(RW - 2 * W){px_sh[2*W-1]}}, px_sh};
    r_mag  = r[RW-1] ? -r : r;
    r_ext  = {{(TW - RW){1'b0}}, r_mag};
    sq     = r_ext * r_ext;
    term   = mode_q ? (sq >> FRAC) : r_ext;
    sum    = {{(TW - AW){1'b0}}, acc_q} + term;
    acc_nx = (sum > {{(TW - AW){1'b0}}, {AW{1'b1}}}) ? {AW{1'b1}} : sum[AW-1:0];
    err_nx = (acc_nx > {{NW{1'b0}}, {W{1'b1}}}) ? {W{1'b1}} : acc_nx[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (take) begin
      mem_x[k_q] <= xi;
      mem_y[k_q] <= yi;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      n_q        <= '0;
      k_q        <= '0;
      mode_q     <= 1'b0;
      sx_q       <= '0;
      sy_q       <= '0;
      sxx_q      <= '0;
      sxy_q      <= '0;
      dvd_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      b1w_q      <= '0;
      b0w_q      <= '0;
      dz_q       <= 1'b0;
      acc_q      <= '0;
      b0_q       <= '0;
      b1_q       <= '0;
      err_q      <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        n_q    <= n_clamp;
        mode_q <= err_mode;
        k_q    <= '0;
        sx_q   <= '0;
        sy_q   <= '0;
        sxx_q  <= '0;
        sxy_q  <= '0;
        acc_q  <= '0;
        dz_q   <= 1'b0;
      end
      unique case (state_q)
        StLoad: begin
          if (take) begin
            k_q   <= last_k ? '0 : k_q + NW'(1);
            sx_q  <= sx_q + x_a;
            sy_q  <= sy_q + y_a;
            sxx_q <= sxx_q + xx_a;
            sxy_q <= sxy_q + xy_a;
          end
        end
        StNum: begin
          if (dm_zero) begin
            dz_q  <= 1'b1;
            b1w_q <= '0;
          end else begin
            dvd_q <= {nm_mag, {FRAC{1'b0}}};
            dvs_q <= {{FRAC{1'b0}}, dm_mag};
            rem_q <= '0;
            cnt_q <= '0;
            neg_q <= nm[MW-1] ^ dm[MW-1];
          end
        end
        StB0: begin
          dvd_q <= {{(DW - BW){1'b0}}, num0_mag};
          dvs_q <= {{(DW - NW){1'b0}}, n_q};
          rem_q <= '0;
          cnt_q <= '0;
          neg_q <= num0[BW-1];
        end
        StDivB1, StDivB0: begin
          dvd_q <= quo_nx;
          rem_q <= rem_nx;
          cnt_q <= cnt_q + CW'(1);
          if (div_last) begin
            if (state_q == StDivB1) b1w_q <= q_sat;
            else                    b0w_q <= q_sat;
          end
        end
        StResid: begin
          acc_q <= acc_nx;
          k_q   <= k_q + NW'(1);
          if (last_k) begin
            b0_q       <= b0w_q;
            b1_q       <= b1w_q;
            err_q      <= err_nx;
            div_zero_q <= dz_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regressor_stream.sv
// Directed bench for regressor_stream: hand-computed Q10 fits, handshake corner cases,
// mid-fit reset and saturation at full depth.
module tb_regressor_stream;
  localparam int W     = 20;
  localparam int DEPTH = 150;
  localparam int NW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NW-1:0] num;
  logic          err_mode;
  logic [W-1:0]  xi, yi;
  logic          in_valid;
  logic          in_ready, busy, ready, div_zero;
  logic [W-1:0]  b0, b1, error;

  int xs [DEPTH];
  int ys [DEPTH];
  int checks = 0;
  int errors = 0;

  regressor_stream #(.W(W), .FRAC(10), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .num(num), .err_mode(err_mode),
    .xi(xi), .yi(yi), .in_valid(in_valid), .in_ready(in_ready), .busy(busy),
    .ready(ready), .b0(b0), .b1(b1), .error(error), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input int n, input bit mode);
    start = 1'b1;
    num = NW'(n);
    err_mode = mode;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present samples xs/ys[0..cnt-1]; optional valid gaps and a start pulse at cycle start_at.
  task automatic send(input int cnt, input bit gappy, input int start_at);
    logic [15:0] vpat;
    int i;
    int g;
    vpat = 16'b1011_0010_1110_0101;
    i = 0;
    g = 0;
    while (i < cnt && g < 2000) begin
      start = (g == start_at);
      if (gappy && !vpat[g % 16]) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        xi = W'(xs[i]);
        yi = W'(ys[i]);
        if (in_ready) i++;
      end
      g++;
      @(negedge clk);
    end
    start = 1'b0;
    in_valid = 1'b0;
    check_eq("samples_taken", i, cnt);
  endtask

  task automatic wait_ready(input string tag);
    int c;
    c = 0;
    while (!ready && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check_eq(tag, ready, 1);
  endtask

  task automatic check_fit(input string tag, input int eb1, input int eb0, input int eerr,
                           input int edz);
    check_eq({tag, "_b1"}, $signed(b1), eb1);
    check_eq({tag, "_b0"}, $signed(b0), eb0);
    check_eq({tag, "_err"}, error, eerr);
    check_eq({tag, "_dz"}, div_zero, edz);
  endtask

  task automatic set4(input int x0, x1, x2, x3, y0, y1, y2, y3);
    xs[0] = x0; xs[1] = x1; xs[2] = x2; xs[3] = x3;
    ys[0] = y0; ys[1] = y1; ys[2] = y2; ys[3] = y3;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; num = '0; err_mode = 1'b0;
    xi = '0; yi = '0; in_valid = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_b0", b0, 0);
    check_eq("rst_b1", b1, 0);
    check_eq("rst_err", error, 0);
    check_eq("rst_dz", div_zero, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", ready, 0);
    check_eq("rst_in_ready", in_ready, 0);
    rst = 1'b1;

    // in_valid in IDLE changes nothing
    in_valid = 1'b1; xi = W'(777); yi = W'(555);
    repeat (2) @(negedge clk);
    check_eq("idle_in_ready", in_ready, 0);
    check_eq("idle_busy", busy, 0);
    in_valid = 1'b0;

    // Test 1: y = 2x + 1
    set4(0, 1024, 2048, 3072, 1024, 3072, 5120, 7168);
    pulse_start(4, 1'b0);
    check_eq("t1_busy", busy, 1);
    check_eq("t1_in_ready", in_ready, 1);
    send(4, 1'b0, -1);
    check_eq("t1_in_ready_drop", in_ready, 0);
    wait_ready("t1_ready");
    check_fit("t1", 2048, 1024, 0, 0);

    // Test 2: noisy points, mode 0 then mode 1; ready drops after accepted start
    set4(0, 1024, 2048, 3072, 0, 2048, 2048, 4096);
    pulse_start(4, 1'b0);
    check_eq("t2_ready_fall", ready, 0);
    send(4, 1'b0, -1);
    wait_ready("t2_ready");
    check_fit("t2m0", 1228, 206, 1640, 0);
    pulse_start(4, 1'b1);
    send(4, 1'b0, -1);
    wait_ready("t2m1_ready");
    check_fit("t2m1", 1228, 206, 818, 0);

    // Test 3: vertical data, zero denominator
    xs[0] = 5120; xs[1] = 5120; xs[2] = 5120;
    ys[0] = 1024; ys[1] = 2048; ys[2] = 3072;
    pulse_start(3, 1'b0);
    send(3, 1'b0, -1);
    wait_ready("t3_ready");
    check_fit("t3", 0, 2048, 2048, 1);

    // num=1 clamps to 2
    xs[0] = 0; xs[1] = 1024; ys[0] = 1024; ys[1] = 3072;
    pulse_start(1, 1'b0);
    send(2, 1'b0, -1);
    check_eq("clamp2_in_ready", in_ready, 0);
    wait_ready("clamp2_ready");
    check_fit("clamp2", 2048, 1024, 0, 0);

    // Test 4: garbage sample alongside start, gappy valid, start pulses in LOAD and while busy
    set4(0, 1024, 2048, 3072, 1024, 3072, 5120, 7168);
    start = 1'b1; num = NW'(4); err_mode = 1'b0;
    in_valid = 1'b1; xi = W'(300000); yi = W'(-200000);
    check_eq("t4_in_ready_at_start", in_ready, 0);
    @(negedge clk);
    start = 1'b0;
    send(4, 1'b1, 3);
    repeat (3) @(negedge clk);
    start = 1'b1; num = NW'(3); err_mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("t4_busy", busy, 1);
    check_eq("t4_in_ready_busy", in_ready, 0);
    wait_ready("t4_ready");
    check_fit("t4", 2048, 1024, 0, 0);
    check_eq("t4_in_ready_done", in_ready, 0);

    // Test 5: reset pulse mid-divide
    set4(0, 1024, 2048, 3072, 0, 2048, 2048, 4096);
    pulse_start(4, 1'b0);
    send(4, 1'b0, -1);
    repeat (10) @(negedge clk);
    check_eq("t5_busy_pre", busy, 1);
    rst = 1'b0;
    #1;
    check_fit("t5_rst", 0, 0, 0, 0);
    check_eq("t5_rst_busy", busy, 0);
    check_eq("t5_rst_ready", ready, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t5_idle_busy", busy, 0);
    set4(0, 1024, 2048, 3072, 1024, 3072, 5120, 7168);
    pulse_start(4, 1'b0);
    send(4, 1'b0, -1);
    wait_ready("t5_ready");
    check_fit("t5", 2048, 1024, 0, 0);

    // Test 6: full depth (num=200 clamps to DEPTH), steep slope saturates b1 and error
    for (int i = 0; i < DEPTH; i++) begin
      xs[i] = (i % 2 == 0) ? 1 : -1;
      ys[i] = (i % 2 == 0) ? -524287 : 524287;
    end
    pulse_start(200, 1'b0);
    send(DEPTH, 1'b0, -1);
    check_eq("t6_in_ready_drop", in_ready, 0);
    wait_ready("t6_ready");
    check_fit("t6", -524288, 0, 1048575, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
